fifo_rd_seq_checker: RTL
========================

// Module: fifo_rd_seq_checker
// PURPOSE
//  Read-side consumer for the 16->32 asymmetric FIFO. Paces rd_en from FIFO flags and checks the packed
//  incrementing 16-bit sequence on every rd_valid beat. Reports a sticky error, error/beat counts, sync status.
//  Lives in the rd_clk_i domain directly downstream of the FIFO, replacing the golden-FIFO compare path.
// PARAMETERS
//  DATA_WIDTH     32  FIFO read width; must equal 2*WORD_WIDTH
//  WORD_WIDTH     16  width of one written sequence word
//  CNT_WIDTH      16  width of err_cnt_o; saturating
//  BEAT_CNT_WIDTH 32  width of beat_cnt_o; wraps
// PORTS
//  rd_clk_i     in   1              checker clock (FIFO read clock)
//  sys_rst_n    in   1              async active-low reset
//  rst_busy_i   in   1              FIFO reset in progress; high forces IDLE
//  prog_full_i  in   1              FIFO programmable-full; arms reading
//  empty_i      in   1              FIFO empty flag
//  stop_rd_n_i  in   1              push button, active low; low gates rd_en_o
//  clear_i      in   1              sync clear of counters/sticky error (pulse)
//  rd_en_o      out  1              FIFO read enable
//  rdata_i      in   DATA_WIDTH     FIFO read data
//  rd_valid_i   in   1              rdata_i valid this cycle
//  synced_o     out  1              expected-value seeded, checking active
//  err_o        out  1              sticky mismatch flag
//  err_cnt_o    out  CNT_WIDTH      mismatching beats, saturating
//  beat_cnt_o   out  BEAT_CNT_WIDTH valid beats checked
//  err_data_o   out  DATA_WIDTH     first failing rdata_i     (capture option)
//  err_exp_o    out  DATA_WIDTH     expected value at first failure (capture option)
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE, exp 0. One clock; sys_rst_n asserts async, deasserts sync to rd_clk_i.
//  FSM IDLE->ARMED when !rst_busy_i && prog_full_i (single cycle, level). ARMED->SYNC next cycle.
//   SYNC->CHECK on first rd_valid_i beat. Any state->IDLE while rst_busy_i=1 (counters held, synced_o=0).
//  rd_en_o registered: next = (state!=IDLE) && !empty_i && stop_rd_n_i; 1-cycle lag on flags tolerated
//   (FIFO ignores reads while empty).
//  Packing: rdata_i = {older word [31:16], newer word [15:0]}; legal beat: lo == hi+1 (mod 2^WORD_WIDTH).
//  SYNC beat: no compare; exp <= rdata_i[15:0]+1; synced_o <= 1; beat_cnt_o +1.
//  CHECK beat: pass iff rdata_i[31:16]==exp && rdata_i[15:0]==exp+1. Always exp <= rdata_i[15:0]+1
//   (resync on observed data, so one bad beat counts once). beat_cnt_o +1 every beat.
//  Fail: err_o <= 1 (sticky), err_cnt_o +1 saturating at all-ones; result visible cycle after the beat.
//  Wrap: 16'hFFFF/16'h0000 within or across beats is legal; all arithmetic mod 2^WORD_WIDTH.
//  clear_i: counters, err_o, capture regs <= 0 next cycle; priority over a same-cycle failure (dropped).
//   FSM, exp and synced_o unaffected.
//  rd_valid_i outside SYNC/CHECK ignored. stop_rd_n_i low mid-run: reads pause, sync kept, no error.
// CONFIGURATION
//  `define FIFO_CHK_ERR_CAPTURE_EN: first failure since reset/clear latches rdata_i->err_data_o and
//   {exp,exp+1}->err_exp_o; later failures don't overwrite.
//  Without it: err_data_o/err_exp_o tied 0, no capture registers.
// STRUCTURE
//  Package fifo_chk_pkg: state enum {IDLE,ARMED,SYNC,CHECK}; WORD_WIDTH/DATA_WIDTH localparams;
//   function next_word(w) = w+1 mod 2^WORD_WIDTH.
//  One sub-module fifo_chk_sat_cnt (parameterised width, inc/clr, saturate option) for err/beat counters.
// TESTING
//  1 reset; rst_busy_i=0, prog_full_i=1, empty_i=0 -> rd_en_o=1 two cycles later; all other outputs 0.
//  2 beats 32'h0001_0002, 0003_0004, 0005_0006 -> synced_o=1 after 1st, err_o=0, beat_cnt_o=3.
//  3 beats FFFD_FFFE, FFFF_0000, 0001_0002 -> no error across wrap; beat_cnt_o=3.
//  4 after 0003_0004 send 0007_0008 then 0009_000A -> err_cnt_o=1, err_o=1; with macro
//    err_data_o=0007_0008, err_exp_o=0005_0006.
//  5 error beat and clear_i same cycle -> err_cnt_o=0, err_o=0; saturation: force 2^CNT_WIDTH+3 errors
//    -> err_cnt_o=16'hFFFF.
//  6 rst_busy_i=1 mid-CHECK -> rd_en_o=0, synced_o=0, next first beat 1234_1235 reseeds with no error.

Source files
------------

// File: rtl/fifo_chk_pkg.sv
// Shared types and helpers for the FIFO read-side sequence checker.
//   chk_state_e : checker FSM states
//   WORD_WIDTH  : width of one written sequence word
//   DATA_WIDTH  : FIFO read width (two packed words)
//   next_word() : sequence successor, wraps mod 2^WORD_WIDTH
package fifo_chk_pkg;
  localparam int WORD_WIDTH = 16;
  localparam int DATA_WIDTH = 2 * WORD_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_SYNC  = 2'd2,
    ST_CHECK = 2'd3
  } chk_state_e;

  function automatic logic [WORD_WIDTH-1:0] next_word(input logic [WORD_WIDTH-1:0] w);
    return w + WORD_WIDTH'(1);
  endfunction
endpackage

// File: rtl/fifo_chk_sat_cnt.sv
// Event counter with synchronous clear and optional saturation.
//   i_clk/i_rst_n : clock, async active-low reset
//   i_clr         : synchronous clear, wins over i_inc
//   i_inc         : count one event
//   o_cnt         : current count (holds at all-ones when SAT=1, wraps otherwise)
module fifo_chk_sat_cnt #(
  parameter int WIDTH = 16,
  parameter bit SAT   = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_cnt
);
  logic [WIDTH-1:0] r_cnt;
  logic             w_hold;

  assign w_hold = SAT && (&r_cnt);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)              r_cnt <= '0;
    else if (i_clr)            r_cnt <= '0;
    else if (i_inc && !w_hold) r_cnt <= r_cnt + WIDTH'(1);
  end

  assign o_cnt = r_cnt;
endmodule

// File: rtl/fifo_rd_seq_checker.sv
// Read-side consumer for the 16->32 asymmetric FIFO. Paces rd_en_o from the
// FIFO flags and checks that every valid beat carries two consecutive words of
// an incrementing sequence, packed {older, newer}.
//   rd_clk_i, sys_rst_n      : clock, async active-low reset
//   rst_busy_i               : FIFO reset in progress, forces IDLE
//   prog_full_i, empty_i     : FIFO flags; prog_full arms reading
//   stop_rd_n_i              : low pauses reads
//   clear_i                  : clears counters, sticky error, capture
//   rd_en_o                  : FIFO read enable (registered)
//   rdata_i, rd_valid_i      : FIFO read data / valid
//   synced_o                 : expected value seeded, checking active
//   err_o, err_cnt_o         : sticky error, saturating error count
//   beat_cnt_o               : valid beats checked (wraps)
//   err_data_o, err_exp_o    : first failing beat and its expected value
// Optional: define FIFO_CHK_ERR_CAPTURE_EN to build the first-failure capture
// registers; otherwise err_data_o/err_exp_o are tied to 0.
module fifo_rd_seq_checker #(
  parameter int DATA_WIDTH     = 32,
  parameter int WORD_WIDTH     = 16,
  parameter int CNT_WIDTH      = 16,
  parameter int BEAT_CNT_WIDTH = 32
) (
  input  logic                      rd_clk_i,
  input  logic                      sys_rst_n,
  input  logic                      rst_busy_i,
  input  logic                      prog_full_i,
  input  logic                      empty_i,
  input  logic                      stop_rd_n_i,
  input  logic                      clear_i,
  output logic                      rd_en_o,
  input  logic [DATA_WIDTH-1:0]     rdata_i,
  input  logic                      rd_valid_i,
  output logic                      synced_o,
  output logic                      err_o,
  output logic [CNT_WIDTH-1:0]      err_cnt_o,
  output logic [BEAT_CNT_WIDTH-1:0] beat_cnt_o,
  output logic [DATA_WIDTH-1:0]     err_data_o,
  output logic [DATA_WIDTH-1:0]     err_exp_o
);
  import fifo_chk_pkg::*;

  chk_state_e            r_state;
  logic [WORD_WIDTH-1:0] r_exp;
  logic                  r_synced;
  logic                  r_rd_en;
  logic                  r_err;

  logic [WORD_WIDTH-1:0] w_hi, w_lo, w_exp_p1, w_lo_p1;
  logic                  w_beat, w_fail;

  assign w_hi     = rdata_i[DATA_WIDTH-1 -: WORD_WIDTH];
  assign w_lo     = rdata_i[WORD_WIDTH-1:0];
  assign w_exp_p1 = next_word(r_exp);
  assign w_lo_p1  = next_word(w_lo);

  // Beats only count while seeding or checking, and never during FIFO reset.
  assign w_beat = rd_valid_i && !rst_busy_i &&
                  ((r_state == ST_SYNC) || (r_state == ST_CHECK));
  assign w_fail = w_beat && (r_state == ST_CHECK) &&
                  !((w_hi == r_exp) && (w_lo == w_exp_p1));

  always_ff @(posedge rd_clk_i or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state  <= ST_IDLE;
      r_exp    <= '0;
      r_synced <= 1'b0;
      r_rd_en  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      // Gating by rst_busy_i drops rd_en on the same edge the FSM goes IDLE.
      r_rd_en <= !rst_busy_i && (r_state != ST_IDLE) && !empty_i && stop_rd_n_i;

      if (rst_busy_i) begin
        r_state  <= ST_IDLE;
        r_synced <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE:  if (prog_full_i) r_state <= ST_ARMED;
          ST_ARMED: r_state <= ST_SYNC;
          ST_SYNC:  if (rd_valid_i) begin
                      r_state  <= ST_CHECK;
                      r_synced <= 1'b1;
                    end
          default:  r_state <= ST_CHECK;
        endcase
      end

      // Always resync on observed data so a single bad beat is counted once.
      if (w_beat) r_exp <= w_lo_p1;

      if (clear_i)     r_err <= 1'b0;
      else if (w_fail) r_err <= 1'b1;
    end
  end

  fifo_chk_sat_cnt #(.WIDTH(CNT_WIDTH), .SAT(1'b1)) u_err_cnt (
    .i_clk   (rd_clk_i),
    .i_rst_n (sys_rst_n),
    .i_clr   (clear_i),
    .i_inc   (w_fail),
    .o_cnt   (err_cnt_o)
  );

  fifo_chk_sat_cnt #(.WIDTH(BEAT_CNT_WIDTH), .SAT(1'b0)) u_beat_cnt (
    .i_clk   (rd_clk_i),
    .i_rst_n (sys_rst_n),
    .i_clr   (clear_i),
    .i_inc   (w_beat),
    .o_cnt   (beat_cnt_o)
  );

`ifdef FIFO_CHK_ERR_CAPTURE_EN
  logic                  r_cap_done;
  logic [DATA_WIDTH-1:0] r_err_data, r_err_exp;

  always_ff @(posedge rd_clk_i or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_cap_done <= 1'b0;
      r_err_data <= '0;
      r_err_exp  <= '0;
    end else if (clear_i) begin
      r_cap_done <= 1'b0;
      r_err_data <= '0;
      r_err_exp  <= '0;
    end else if (w_fail && !r_cap_done) begin
      r_cap_done <= 1'b1;
      r_err_data <= rdata_i;
      r_err_exp  <= {r_exp, w_exp_p1};
    end
  end

  assign err_data_o = r_err_data;
  assign err_exp_o  = r_err_exp;
`else
  assign err_data_o = '0;
  assign err_exp_o  = '0;
`endif

  assign rd_en_o  = r_rd_en;
  assign synced_o = r_synced;
  assign err_o    = r_err;
endmodule
